// File: rtl/ctrl_input_mapper.sv
// Controller front end: per-bit debounce, active channel selection and
// mapping of button / analog rises to a single held turn request.
// All filtering and mapping advance on tick; outputs are registered.
//
// Handshake: turn_valid/turn_kind form a held request. It stays asserted
// until consume is seen with turn_valid=1. A new request in the same cycle
// as consume wins, so turn_valid stays 1 with the new kind. A change of
// active channel drops the pending request.
module ctrl_input_mapper #(
   parameter int NUM_CTRL   = 2,
   parameter int DEBOUNCE   = 3,
   parameter int MIC_W      = 8,
   parameter int MIC_THRESH = 64,
   localparam int SEL_W     = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tick,
   input  logic [NUM_CTRL*8-1:0]     ch_btns,
   input  logic [NUM_CTRL*MIC_W-1:0] ch_level,
   input  logic                      auto_sel,
   input  logic [SEL_W-1:0]          man_sel,
   input  logic                      ctrl_mode,
   input  logic [1:0]                pacman_dir,
   input  logic                      consume,
   output logic [SEL_W-1:0]          active_ch,
   output logic                      start_pulse,
   output logic                      turn_valid,
   output logic [1:0]                turn_kind
);

   localparam int NB = NUM_CTRL * 8;
   localparam logic [3:0]       DB_LAST = 4'(DEBOUNCE - 1);
   localparam logic [MIC_W-1:0] THRESH  = MIC_W'(MIC_THRESH);
   localparam logic [SEL_W:0]   NUM_L   = (SEL_W + 1)'(NUM_CTRL);

   // Button bit positions inside one channel byte.
   localparam int B_START = 7;
   localparam int B_UP    = 6;
   localparam int B_DOWN  = 5;
   localparam int B_LEFT  = 4;
   localparam int B_RIGHT = 3;
   localparam int B_LTURN = 2;
   localparam int B_RTURN = 1;
   localparam int B_UBTN  = 0;

   localparam logic [1:0] K_LEFT  = 2'b00;
   localparam logic [1:0] K_RIGHT = 2'b01;
   localparam logic [1:0] K_UTURN = 2'b10;

   logic [NB-1:0]      filt_q, filt_d;
   logic [3:0]         cnt_q [NB];
   logic [3:0]         cnt_d [NB];
   logic [MIC_W-1:0]   lvl_prev_q [NUM_CTRL];
   logic [SEL_W-1:0]   active_q, active_d;
   logic               start_pulse_q, start_pulse_d;
   logic               turn_valid_q, turn_valid_d;
   logic [1:0]         turn_kind_q, turn_kind_d;

   logic [NB-1:0]      rise;
   logic [7:0]         act_rise;
   logic               act_lturn_hi, act_rturn_hi;
   logic [MIC_W-1:0]   act_lvl, act_lvl_prev;
   logic               any_start;
   logic [SEL_W-1:0]   start_sel;
   logic               act_change;
   logic               req_l, req_r, req_u;

   // Per-bit debounce: filtered bit follows raw only after DEBOUNCE
   // consecutive disagreeing ticks; any agreeing tick restarts the count.
   always_comb begin
      filt_d = filt_q;
      for (int b = 0; b < NB; b++) begin
         cnt_d[b] = cnt_q[b];
         if (tick) begin
            if (ch_btns[b] != filt_q[b]) begin
               if (cnt_q[b] == DB_LAST) begin
                  filt_d[b] = ch_btns[b];
                  cnt_d[b]  = 4'd0;
               end else begin
                  cnt_d[b] = cnt_q[b] + 4'd1;
               end
            end else begin
               cnt_d[b] = 4'd0;
            end
         end
      end
   end

   // Rising edges of the filtered bits seen on this tick. filt_q is the
   // value registered at the previous tick, so it serves as the prev copy;
   // using filt_d gives the one-clk latency from the qualifying tick.
   assign rise = tick ? (filt_d & ~filt_q) : '0;

   // Active-channel views and lowest-index start rise.
   always_comb begin
      act_rise     = '0;
      act_lturn_hi = 1'b0;
      act_rturn_hi = 1'b0;
      act_lvl      = '0;
      act_lvl_prev = '0;
      any_start    = 1'b0;
      start_sel    = '0;
      for (int c = 0; c < NUM_CTRL; c++) begin
         if (SEL_W'(c) == active_q) begin
            act_rise     = rise[c*8 +: 8];
            act_lturn_hi = filt_d[c*8 + B_LTURN];
            act_rturn_hi = filt_d[c*8 + B_RTURN];
            act_lvl      = ch_level[c*MIC_W +: MIC_W];
            act_lvl_prev = lvl_prev_q[c];
         end
      end
      for (int c = NUM_CTRL - 1; c >= 0; c--) begin
         if (rise[c*8 + B_START]) begin
            any_start = 1'b1;
            start_sel = SEL_W'(c);
         end
      end
   end

   // Channel selection: manual follows man_sel every clk (out-of-range
   // holds), automatic jumps to the lowest channel with a start rise.
   always_comb begin
      active_d = active_q;
      if (!auto_sel) begin
         if ({1'b0, man_sel} < NUM_L) active_d = man_sel;
      end else if (any_start) begin
         active_d = start_sel;
      end
   end

   assign act_change = (active_d != active_q);

   // Map rises of the active channel to left/right/u-turn candidates.
   always_comb begin
      req_l = 1'b0;
      req_r = 1'b0;
      req_u = 1'b0;
      if (ctrl_mode) begin
         unique case (pacman_dir)
            2'b00: begin
               req_l = act_rise[B_UP];
               req_r = act_rise[B_DOWN];
               req_u = act_rise[B_LEFT];
            end
            2'b01: begin
               req_l = act_rise[B_LEFT];
               req_r = act_rise[B_RIGHT];
               req_u = act_rise[B_DOWN];
            end
            2'b10: begin
               req_l = act_rise[B_RIGHT];
               req_r = act_rise[B_LEFT];
               req_u = act_rise[B_UP];
            end
            default: begin
               req_l = act_rise[B_DOWN];
               req_r = act_rise[B_UP];
               req_u = act_rise[B_RIGHT];
            end
         endcase
      end else begin
         req_l = act_rise[B_LTURN];
         req_r = act_rise[B_RTURN];
         req_u = act_rise[B_UBTN] |
                 (tick && (act_lvl > THRESH) && (act_lvl_prev <= THRESH) &&
                  !act_lturn_hi && !act_rturn_hi);
      end
   end

   // Request register and start pulse: channel change dominates, then a
   // new request (left > right > u-turn), then consume.
   always_comb begin
      turn_valid_d  = turn_valid_q;
      turn_kind_d   = turn_kind_q;
      start_pulse_d = act_rise[B_START] & ~act_change;
      if (act_change) begin
         turn_valid_d = 1'b0;
      end else if (req_l) begin
         turn_valid_d = 1'b1;
         turn_kind_d  = K_LEFT;
      end else if (req_r) begin
         turn_valid_d = 1'b1;
         turn_kind_d  = K_RIGHT;
      end else if (req_u) begin
         turn_valid_d = 1'b1;
         turn_kind_d  = K_UTURN;
      end else if (consume) begin
         turn_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q        <= '0;
         for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
         for (int c = 0; c < NUM_CTRL; c++) lvl_prev_q[c] <= '0;
         active_q      <= '0;
         start_pulse_q <= 1'b0;
         turn_valid_q  <= 1'b0;
         turn_kind_q   <= 2'b00;
      end else begin
         filt_q        <= filt_d;
         cnt_q         <= cnt_d;
         if (tick) begin
            for (int c = 0; c < NUM_CTRL; c++) lvl_prev_q[c] <= ch_level[c*MIC_W +: MIC_W];
         end
         active_q      <= active_d;
         start_pulse_q <= start_pulse_d;
         turn_valid_q  <= turn_valid_d;
         turn_kind_q   <= turn_kind_d;
      end
   end

   assign active_ch   = active_q;
   assign start_pulse = start_pulse_q;
   assign turn_valid  = turn_valid_q;
   assign turn_kind   = turn_kind_q;

endmodule
